// File: rtl/dm_if.sv
// Request/response channel between a CPU data port and its memory responder.
interface dm_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_dmtype;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_dmtype, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_dmtype, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dm_responder.sv
// Data-memory responder: one load/store at a time, fixed access latency,
// registered response held until the requester takes it.
module dm_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  dm_if.slave               bus,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [31:0]       dbg_data
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q;
  logic               we_p0;
  logic [ADDR_W+1:0]  addr_p0;
  logic [31:0]        wdata_p0;
  logic [2:0]         dmtype_p0;
  logic [31:0]        rdata_q;
  logic               err_q;
  logic [31:0]        mem [0:(1<<ADDR_W)-1] = '{default: '0};

  logic               accept;
  logic               access;
  logic               req_err;
  logic [ADDR_W-1:0]  widx;
  logic [31:0]        cur_word;

  function automatic logic bad_req(input logic [31:0] addr, input logic [2:0] dmt);
    logic hi;
    hi = |addr[31:ADDR_W+2];
    case (dmt)
      3'd0:       return hi | (|addr[1:0]);
      3'd1, 3'd2: return hi | addr[0];
      3'd3, 3'd4: return hi;
      default:    return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] off,
                                              input logic [2:0] dmt, input logic [31:0] wdata);
    logic [31:0] w;
    w = word;
    case (dmt)
      3'd0: w = wdata;
      3'd1, 3'd2: begin
        if (off[1]) w[31:16] = wdata[15:0];
        else        w[15:0]  = wdata[15:0];
      end
      default: begin
        case (off)
          2'd0:    w[7:0]   = wdata[7:0];
          2'd1:    w[15:8]  = wdata[7:0];
          2'd2:    w[23:16] = wdata[7:0];
          default: w[31:24] = wdata[7:0];
        endcase
      end
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] off,
                                           input logic [2:0] dmt);
    logic signed [15:0] h;
    logic signed [7:0]  b;
    logic [31:0]        r;
    h = off[1] ? word[31:16] : word[15:0];
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    case (dmt)
      3'd1:    r = {{16{h[15]}}, h};
      3'd2:    r = {16'b0, h};
      3'd3:    r = {{24{b[7]}}, b};
      3'd4:    r = {24'b0, b};
      default: r = word;
    endcase
    return r;
  endfunction

  assign accept   = (state_q == IDLE) && bus.req_valid;
  assign access   = (state_q == WAIT) && (cnt_q == 4'd0);
  assign req_err  = bad_req(bus.req_addr, bus.req_dmtype);
  assign widx     = addr_p0[ADDR_W+1:2];
  assign cur_word = mem[widx];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = req_err ? RESP : WAIT;
      WAIT:    if (cnt_q == 4'd0) state_d = RESP;
      RESP:    if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q   <= 4'(LATENCY - 1);
        err_q   <= req_err;
        rdata_q <= 32'd0;
      end else if (access) begin
        err_q   <= 1'b0;
        rdata_q <= we_p0 ? 32'd0 : load_ext(cur_word, addr_p0[1:0], dmtype_p0);
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  // Request capture: p0 holds the accepted request until its access edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0     <= bus.req_we;
      addr_p0   <= bus.req_addr[ADDR_W+1:0];
      wdata_p0  <= bus.req_wdata;
      dmtype_p0 <= bus.req_dmtype;
    end
  end

  // Reset on the access edge suppresses the write along with the response.
  always_ff @(posedge clk) begin
    if (access && we_p0 && !reset)
      mem[widx] <= store_merge(cur_word, addr_p0[1:0], dmtype_p0, wdata_p0);
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign dbg_data       = mem[dbg_addr];

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: directed cases then randomized traffic against a byte-level memory model.
module tb_dm_responder;
  localparam int LAT0 = 2;

  logic       clk = 1'b0;
  logic       reset0, reset1;
  logic [9:0] dbg_addr0, dbg_addr1;
  logic [31:0] dbg_data0, dbg_data1;
  int vectors = 0;
  int errs    = 0;
  logic [31:0] model_mem [1024];

  dm_if b0 ();
  dm_if b1 ();

  dm_responder #(.ADDR_W(10), .LATENCY(LAT0)) u_dut0 (
    .clk(clk), .reset(reset0), .bus(b0), .dbg_addr(dbg_addr0), .dbg_data(dbg_data0));
  dm_responder #(.ADDR_W(10), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset1), .bus(b1), .dbg_addr(dbg_addr1), .dbg_data(dbg_data1));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_at(input int unsigned a);
    return model_mem[a >> 2][8*(a % 4) +: 8];
  endfunction

  // Reference: access width in bytes, little-endian assembly, arithmetic sign extension.
  function automatic void model_access(input logic we, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [2:0] dmt,
                                       output logic err, output logic [31:0] rd);
    int unsigned n;
    longint v;
    n   = (dmt == 3'd0) ? 4 : (dmt <= 3'd2) ? 2 : 1;
    err = (dmt > 3'd4) || (addr % n != 0) || (addr >= 32'h1000);
    rd  = 32'd0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < int'(n); i++)
        model_mem[(addr + i) >> 2][8*((addr + i) % 4) +: 8] = wdata[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < int'(n); i++)
        v = v | (longint'(byte_at(addr + i)) << (8*i));
      if ((dmt == 3'd1 || dmt == 3'd3) && v[8*n-1])
        v = v - (64'sd1 <<< (8*n));
      rd = v[31:0];
    end
  endfunction

  task automatic transact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] dmt, input int hold);
    logic        e;
    logic [31:0] r;
    logic [31:0] held;
    int          n;
    dbg_addr0     = addr[11:2];
    b0.req_valid  = 1'b1;
    b0.req_we     = we;
    b0.req_addr   = addr;
    b0.req_wdata  = wdata;
    b0.req_dmtype = dmt;
    check("req_ready_idle", b0.req_ready, 1);
    @(posedge clk); #1;
    model_access(we, addr, wdata, dmt, e, r);
    b0.req_valid  = 1'b0;
    b0.req_we     = 1'($urandom);
    b0.req_addr   = $urandom;
    b0.req_wdata  = $urandom;
    b0.req_dmtype = 3'($urandom);
    check("req_ready_busy", b0.req_ready, 0);
    n = 1;
    while (!b0.resp_valid && n < 40) begin
      b0.resp_ready = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    b0.resp_ready = 1'b0;
    check("latency", n, e ? 1 : LAT0 + 1);
    check("resp_rdata", b0.resp_rdata, r);
    check("resp_err", b0.resp_err, e);
    check("dbg_word", dbg_data0, model_mem[addr[11:2]]);
    held = b0.resp_rdata;
    for (int i = 0; i < hold; i++) begin
      b0.req_valid  = 1'b1;
      b0.req_we     = 1'b1;
      b0.req_addr   = 32'($urandom_range(0, 255)) & ~32'd3;
      b0.req_wdata  = $urandom;
      b0.req_dmtype = 3'd0;
      @(posedge clk); #1;
      check("hold_valid", b0.resp_valid, 1);
      check("hold_rdata", b0.resp_rdata, held);
      check("hold_ready", b0.req_ready, 0);
    end
    b0.resp_ready = 1'b1;
    @(posedge clk); #1;
    b0.resp_ready = 1'b0;
    b0.req_valid  = 1'b0;
    check("release_valid", b0.resp_valid, 0);
    check("release_ready", b0.req_ready, 1);
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  d;
    foreach (model_mem[i]) model_mem[i] = 32'd0;
    reset0 = 1'b1; reset1 = 1'b1;
    dbg_addr0 = '0; dbg_addr1 = '0;
    b0.req_valid = 1'b0; b0.req_we = 1'b0; b0.req_addr = '0; b0.req_wdata = '0;
    b0.req_dmtype = '0; b0.resp_ready = 1'b0;
    b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_addr = '0; b1.req_wdata = '0;
    b1.req_dmtype = '0; b1.resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset0 = 1'b0; reset1 = 1'b0;

    check("rst_req_ready", b0.req_ready, 1);
    check("rst_resp_valid", b0.resp_valid, 0);
    check("rst_resp_err", b0.resp_err, 0);
    check("rst_resp_rdata", b0.resp_rdata, 0);

    // Reset during the first WAIT cycle drops the pending store.
    dbg_addr0 = 10'd8;
    b0.req_valid = 1'b1; b0.req_we = 1'b1; b0.req_addr = 32'h20;
    b0.req_wdata = 32'h12345678; b0.req_dmtype = 3'd0;
    @(posedge clk); #1;
    b0.req_valid = 1'b0;
    reset0 = 1'b1;
    @(posedge clk); #1;
    reset0 = 1'b0;
    check("rstwait_ready", b0.req_ready, 1);
    check("rstwait_valid", b0.resp_valid, 0);
    @(posedge clk); #1;
    check("rstwait_mem8", dbg_data0, 0);

    // LATENCY=1: reset coinciding with the access edge blocks the write.
    dbg_addr1 = 10'd8;
    b1.req_valid = 1'b1; b1.req_we = 1'b1; b1.req_addr = 32'h20;
    b1.req_wdata = 32'h12345678; b1.req_dmtype = 3'd0;
    @(posedge clk); #1;
    b1.req_valid = 1'b0;
    reset1 = 1'b1;
    @(posedge clk); #1;
    reset1 = 1'b0;
    check("rstacc_mem8", dbg_data1, 0);
    check("rstacc_valid", b1.resp_valid, 0);
    check("rstacc_ready", b1.req_ready, 1);

    // LATENCY=1 normal store: response after the edge following acceptance.
    dbg_addr1 = 10'd9;
    b1.req_valid = 1'b1; b1.req_we = 1'b1; b1.req_addr = 32'h24;
    b1.req_wdata = 32'hCAFEF00D; b1.req_dmtype = 3'd0;
    @(posedge clk); #1;
    b1.req_valid = 1'b0;
    check("lat1_wait_valid", b1.resp_valid, 0);
    @(posedge clk); #1;
    check("lat1_resp_valid", b1.resp_valid, 1);
    check("lat1_mem9", dbg_data1, 32'hCAFEF00D);
    b1.resp_ready = 1'b1;
    @(posedge clk); #1;
    b1.resp_ready = 1'b0;
    check("lat1_idle", b1.req_ready, 1);
    dbg_addr1 = 10'd8;
    check("lat1_mem8", dbg_data1, 0);

    // Directed cases on the LATENCY=2 instance.
    transact(1'b1, 32'h10, 32'hDEADBEEF, 3'd0, 0);
    transact(1'b0, 32'h10, 32'h0, 3'd0, 0);
    transact(1'b1, 32'h12, 32'h0000005A, 3'd3, 0);
    transact(1'b0, 32'h12, 32'h0, 3'd3, 0);
    check("dbg_byte_merge", dbg_data0, 32'hDE5ABEEF);
    transact(1'b0, 32'h13, 32'h0, 3'd3, 0);
    transact(1'b0, 32'h13, 32'h0, 3'd4, 0);
    transact(1'b1, 32'h16, 32'h00008001, 3'd1, 0);
    transact(1'b0, 32'h16, 32'h0, 3'd1, 0);
    transact(1'b0, 32'h16, 32'h0, 3'd2, 0);
    transact(1'b0, 32'h14, 32'h0, 3'd2, 0);
    transact(1'b0, 32'h11, 32'h0, 3'd1, 0);
    transact(1'b1, 32'h12, 32'hFFFFFFFF, 3'd0, 0);
    transact(1'b0, 32'h1000, 32'h0, 3'd0, 0);
    transact(1'b0, 32'h10, 32'h0, 3'd7, 0);
    transact(1'b0, 32'h10, 32'h0, 3'd0, 5);
    transact(1'b1, 32'h11, 32'h000000A5, 3'd4, 5);

    // Randomized traffic, including occasional illegal types and addresses.
    for (int i = 0; i < 200; i++) begin
      d = ($urandom % 8 == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      a = ($urandom % 16 == 0) ? $urandom : 32'($urandom_range(0, 255));
      transact(1'($urandom), a, $urandom, d, int'($urandom % 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder: the memory end of the CPU's data-memory interface.
- Accepts one load/store request at a time over a valid/ready handshake and applies the access size and sign selected by the DMType code.
- Answers after a programmable latency with a registered response.
- Replaces the ideal combinational data memory so the CPU and its multicycle/pipelined successors can be run against realistic memory timing.

Parameters:
- ADDR_W, 10, word-address width; memory holds 2^ADDR_W 32-bit words.
- LATENCY, 2, cycles between request acceptance and the access edge; legal range 1..15.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_dmtype  in  3  access type: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester takes the response.
- resp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- resp_err  out  1  request rejected.
- dbg_addr  in  ADDR_W  debug word index.
- dbg_data  out  32  combinational read of mem[dbg_addr].

Behaviour:
- FSM states:
  - IDLE: req_ready=1.
  - WAIT: req_ready=0.
  - RESP: req_ready=0, resp_valid=1.
  - No request overlap.
- Reset: state IDLE, resp_valid=0, resp_err=0, resp_rdata=0, wait counter 0. Memory array is not cleared by reset; it is zero-initialised at time zero.
- Acceptance: edge k with state IDLE and req_valid=1. Latch we, addr, wdata and dmtype at that edge. Inputs are don't-care afterwards.
- Error check at acceptance. An error is raised for any of:
  - dmtype > 100;
  - half access with addr[0]=1;
  - word access with addr[1:0]!=00;
  - addr[31:ADDR_W+2] != 0.
- On error: go straight to RESP after edge k with resp_err=1 and resp_rdata=0. Memory is untouched.
- Normal path:
  - Enter WAIT with cnt=LATENCY-1. Each WAIT edge decrements cnt.
  - At the edge where cnt==0 (edge k+LATENCY), the access is performed and the state goes to RESP.
  - resp_valid first visible after edge k+LATENCY.
- Store lanes, word index addr[ADDR_W+1:2]:
  - byte: lane addr[1:0] gets wdata[7:0];
  - half: bytes {addr[1],0} and {addr[1],1} get wdata[15:0];
  - word: whole word.
  - Other bytes are preserved.
  - resp_rdata=0, resp_err=0.
- Load: select the lane the same way; sign-extend for 001/011, zero-extend for 010/100, word as-is. resp_err=0.
- Memory is read at the access edge, so a load sees all earlier completed stores.
- RESP:
  - resp_valid, resp_rdata and resp_err are held stable until the edge where resp_ready=1. That edge moves to IDLE with resp_valid=0.
  - resp_ready is ignored outside RESP.
- req_valid while not IDLE: ignored. The requester must hold it; it is not queued.
- Reset in WAIT before the access edge: the pending store is dropped (memory unchanged). Reset at the access edge also wins, so no write happens.
- dbg_data reflects the array combinationally, including a write on the cycle after the access edge.

Test Plan:
- LATENCY=2. Word store 0xDEADBEEF to 0x10, then word load 0x10 → store response 3 edges after accept is not needed; timing check: req_ready low after accept edge, resp_valid rises after edge k+2, load returns 0xDEADBEEF, dbg_addr=4 shows 0xDEADBEEF.
- Mem[4]=0xDEADBEEF. Byte store 0x5A to 0x12, then loads at 0x12:
  - byte signed → 0x0000005A;
  - dbg word → 0xDE5ABEEF;
  - byte signed at 0x13 → 0xFFFFFFDE;
  - byte unsigned at 0x13 → 0x000000DE.
- Half store 0x8001 to 0x16:
  - half signed load → 0xFFFF8001;
  - half unsigned load → 0x00008001;
  - mem[5] low half is unchanged.
- Misaligned and range errors:
  - half load at 0x11 → resp_err=1, rdata=0, one edge after accept;
  - word store at 0x12 → resp_err=1, memory unchanged;
  - address 0x1000 with ADDR_W=10 → resp_err=1;
  - dmtype=111 → resp_err=1.
- Backpressure: hold resp_ready=0 for 5 cycles → resp_valid/rdata stable, req_ready=0, a new req_valid is ignored. resp_ready=1 → IDLE next edge, then the held request is accepted.
- Reset mid-operation: store 0x12345678 to 0x20, assert reset in the first WAIT cycle → mem[8] stays 0, state IDLE, resp_valid=0. Repeat with LATENCY=1 and reset coinciding with the access edge → mem[8] stays 0.
